// File: rtl/obi_resp_pkg.sv
// Shared types and helpers for the OBI data-memory responder: response pipeline
// stage, grant-stall FSM states and the byte-lane write merge.
package obi_resp_pkg;

  localparam int unsigned DEFAULT_DEPTH_WORDS = 1024;
  localparam int unsigned IDX_W = $clog2(DEFAULT_DEPTH_WORDS);

  typedef struct packed {
    logic        valid;
    logic [31:0] rdata;
  } resp_stage_t;

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } stall_state_t;

  function automatic logic [31:0] be_merge(input logic [31:0] old,
                                           input logic [31:0] wdata,
                                           input logic [3:0]  be);
    logic [31:0] merged;
    merged = old;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = wdata[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/obi_resp_delay_line.sv
// Fixed-latency response pipeline: stage 0 loads on grant, the last stage is the
// response; the count of valid stages is the granted-but-unanswered total.
module obi_resp_delay_line
  import obi_resp_pkg::*;
#(
  parameter int unsigned LAT   = 1,
  parameter int unsigned CNT_W = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [31:0]      load_data_i,
  output resp_stage_t      head_o,
  output logic [CNT_W-1:0] count_o
);

  resp_stage_t      stage_reg  [LAT];
  resp_stage_t      stage_next [LAT];
  logic [CNT_W-1:0] pop_chain  [LAT+1];

  // Data only moves with a valid token so the head keeps the last delivered word.
  assign stage_next[0] = '{valid: load_i,
                           rdata: load_i ? load_data_i : stage_reg[0].rdata};
  assign pop_chain[0]  = '0;

  for (genvar gi = 0; gi < LAT; gi++) begin : g_stage
    if (gi > 0) begin : g_shift
      assign stage_next[gi] = '{valid: stage_reg[gi-1].valid,
                                rdata: stage_reg[gi-1].valid ? stage_reg[gi-1].rdata
                                                             : stage_reg[gi].rdata};
    end
    assign pop_chain[gi+1] = pop_chain[gi] + CNT_W'(stage_reg[gi].valid);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < LAT; i++) stage_reg[i] <= '0;
    end else begin
      stage_reg <= stage_next;
    end
  end

  assign head_o  = stage_reg[LAT-1];
  assign count_o = pop_chain[LAT];

endmodule

// File: rtl/obi_data_mem_responder.sv
// OBI data-port memory slave: stalled grant, byte-enable RAM, in-order responses
// a fixed number of cycles after each grant, sticky out-of-range flag.
module obi_data_mem_responder
  import obi_resp_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int unsigned DEPTH_WORDS     = 1024,
  parameter int unsigned GNT_STALL       = 0,
  parameter int unsigned RVALID_LAT      = 1,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              data_req_i,
  output logic                              data_gnt_o,
  output logic                              data_rvalid_o,
  input  logic                              data_we_i,
  input  logic [3:0]                        data_be_i,
  input  logic [31:0]                       data_addr_i,
  input  logic [31:0]                       data_wdata_i,
  output logic [31:0]                       data_rdata_o,
  output logic                              oob_o,
  output logic [$clog2(RVALID_LAT+1)-1:0]   outstanding_o
);

  localparam int unsigned OUT_W     = $clog2(RVALID_LAT + 1);
  localparam int unsigned RAM_IDX_W = (DEPTH_WORDS == DEFAULT_DEPTH_WORDS) ? IDX_W
                                                                           : $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W     = (GNT_STALL > 0) ? $clog2(GNT_STALL + 1) : 1;
  localparam logic [CNT_W-1:0] STALL_MAX = CNT_W'(GNT_STALL);

  stall_state_t         state_reg, state_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic                 stall_done;
  logic                 room;
  logic                 gnt;
  logic [OUT_W-1:0]     out_count;
  logic [31:0]          offset;
  logic                 in_range;
  logic [RAM_IDX_W-1:0] idx;
  logic [31:0]          ram_word;
  logic [31:0]          resp_data;
  logic                 oob_reg;
  resp_stage_t          head;

  logic [31:0] ram [DEPTH_WORDS];

  // A response leaving this cycle still occupies a slot.
  assign room = (32'(out_count) < MAX_OUTSTANDING);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    stall_done = (cnt_reg == STALL_MAX);
    gnt        = data_req_i && room && stall_done;
    unique case (state_reg)
      ST_IDLE: begin
        if (data_req_i && !gnt) begin
          state_next = ST_WAIT;
          cnt_next   = stall_done ? cnt_reg : cnt_reg + 1'b1;
        end
      end
      ST_WAIT: begin
        if (gnt || !data_req_i) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else if (!stall_done) begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      oob_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (gnt && !in_range) oob_reg <= 1'b1;
    end
  end

  // Low address bits are dropped by the shift; wrap-around below BASE lands out of range.
  assign offset    = data_addr_i - BASE_ADDR;
  assign in_range  = ((offset >> 2) < DEPTH_WORDS);
  assign idx       = offset[RAM_IDX_W+1:2];
  assign ram_word  = ram[idx];
  assign resp_data = (data_we_i || !in_range) ? 32'h0 : ram_word;

  always_ff @(posedge clk_i) begin
    if (gnt && data_we_i && in_range) begin
      ram[idx] <= be_merge(ram_word, data_wdata_i, data_be_i);
    end
  end

  obi_resp_delay_line #(
    .LAT   (RVALID_LAT),
    .CNT_W (OUT_W)
  ) u_delay_line (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .load_i      (gnt),
    .load_data_i (resp_data),
    .head_o      (head),
    .count_o     (out_count)
  );

  assign data_gnt_o    = gnt;
  assign data_rvalid_o = head.valid;
  assign data_rdata_o  = head.rdata;
  assign oob_o         = oob_reg;
  assign outstanding_o = out_count;

endmodule

// File: tb/tb_obi_data_mem_responder.sv
// Four responder configurations driven by directed then random OBI traffic and
// checked cycle by cycle against a queue-based model of the responder rules.
module tb_obi_data_mem_responder;

  localparam int NI = 4;
  localparam logic [NI-1:0][31:0] BASE_ARR  = {32'h8000_0000, 32'h0000_4000, 32'h1000_0000, 32'h0000_0000};
  localparam logic [NI-1:0][31:0] DEPTH_ARR = {32'd256, 32'd1024, 32'd64, 32'd1024};
  localparam logic [NI-1:0][31:0] STALL_ARR = {32'd1, 32'd0, 32'd3, 32'd0};
  localparam logic [NI-1:0][31:0] LAT_ARR   = {32'd3, 32'd4, 32'd2, 32'd1};
  localparam logic [NI-1:0][31:0] MAX_ARR   = {32'd2, 32'd1, 32'd2, 32'd1};
  localparam int RUN_CYCLES = 1200;

  typedef struct {
    bit          we;
    logic [3:0]  be;
    logic [31:0] off;
    logic [31:0] wdata;
    bit          has_c;
    logic [31:0] cexp;
  } txn_t;

  typedef struct {
    int unsigned due;
    logic [31:0] data;
    bit          known;
    bit          has_c;
    logic [31:0] cexp;
  } rsp_t;

  logic clk = 1'b0;
  logic rst_n;
  bit   run  = 1'b0;
  bit   stop = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic txn_t mk(input bit we, input logic [3:0] be, input logic [31:0] off,
                              input logic [31:0] wd, input bit has_c, input logic [31:0] cexp);
    txn_t t;
    t.we = we; t.be = be; t.off = off; t.wdata = wd; t.has_c = has_c; t.cexp = cexp;
    return t;
  endfunction

  function automatic txn_t rand_txn(input int unsigned depth);
    txn_t t;
    t.we    = 1'($urandom_range(0, 1));
    t.be    = 4'($urandom_range(0, 15));
    t.wdata = $urandom();
    t.has_c = 1'b0;
    t.cexp  = 32'h0;
    case ($urandom_range(0, 15))
      0:       t.off = 32'(depth * 4) + 32'(4 * $urandom_range(0, 3));
      1:       t.off = 32'hFFFF_FFFC;
      default: t.off = 32'(4 * $urandom_range(0, 8)) + 32'($urandom_range(0, 3));
    endcase
    return t;
  endfunction

  for (genvar gi = 0; gi < NI; gi++) begin : g_inst
    localparam logic [31:0] BASE  = BASE_ARR[gi];
    localparam int unsigned DEPTH = DEPTH_ARR[gi];
    localparam int unsigned STALL = STALL_ARR[gi];
    localparam int unsigned LAT   = LAT_ARR[gi];
    localparam int unsigned MAXO  = MAX_ARR[gi];

    logic        req, we, gnt, rvalid, oob;
    logic [3:0]  be;
    logic [31:0] addr, wdata, rdata;
    logic [$clog2(LAT+1)-1:0] outstanding;
    bit          has_c;
    logic [31:0] cexp;
    bit          pro_done   = 1'b0;
    bit          rd_gnt_now = 1'b0;
    bit          gnt_seen   = 1'b0;

    obi_data_mem_responder #(
      .BASE_ADDR       (BASE),
      .DEPTH_WORDS     (DEPTH),
      .GNT_STALL       (STALL),
      .RVALID_LAT      (LAT),
      .MAX_OUTSTANDING (MAXO)
    ) u_dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .data_req_i    (req),
      .data_gnt_o    (gnt),
      .data_rvalid_o (rvalid),
      .data_we_i     (we),
      .data_be_i     (be),
      .data_addr_i   (addr),
      .data_wdata_i  (wdata),
      .data_rdata_o  (rdata),
      .oob_o         (oob),
      .outstanding_o (outstanding)
    );

    // Stimulus: directed prologue, then random traffic with idle gaps and rare early req drops.
    initial begin
      txn_t dir[$];
      txn_t t;
      int   pi;
      req = 1'b0; we = 1'b0; be = 4'h0; addr = 32'h0; wdata = 32'h0; has_c = 1'b0; cexp = 32'h0;
      for (int k = 0; k < 9; k++) dir.push_back(mk(1'b1, 4'hF, 32'(k * 4), 32'hA5A5_0000 + 32'(k), 1'b1, 32'h0));
      dir.push_back(mk(1'b1, 4'hF, 32'h10,   32'hDEAD_BEEF, 1'b1, 32'h0));
      dir.push_back(mk(1'b0, 4'hF, 32'h10,   32'h0,         1'b1, 32'hDEAD_BEEF));
      dir.push_back(mk(1'b1, 4'hF, 32'h20,   32'h1122_3344, 1'b1, 32'h0));
      dir.push_back(mk(1'b1, 4'h5, 32'h20,   32'hAABB_CCDD, 1'b1, 32'h0));
      dir.push_back(mk(1'b0, 4'h0, 32'h20,   32'h0,         1'b1, 32'h11BB_33DD));
      dir.push_back(mk(1'b1, 4'hF, 32'h1000, 32'hCAFE_F00D, 1'b1, 32'h0));
      dir.push_back(mk(1'b0, 4'hF, 32'h1000, 32'h0,         1'b1, 32'h0));
      dir.push_back(mk(1'b0, 4'hF, 32'h0,    32'h0,         1'b1, 32'hA5A5_0000));
      dir.push_back(mk(1'b0, 4'hF, 32'h13,   32'h0,         1'b1, 32'hDEAD_BEEF));
      pi = 0;
      wait (run);
      while (!stop) begin
        @(posedge clk);
        #2;
        if (!rst_n) begin
          req = 1'b0;
        end else if (!req || gnt_seen) begin
          req = 1'b0;
          has_c = 1'b0;
          if (pi < dir.size()) begin
            t = dir[pi];
            pi++;
            req = 1'b1;
          end else begin
            pro_done = 1'b1;
            t = rand_txn(DEPTH);
            req = ($urandom_range(0, 3) != 0);
          end
          if (req) begin
            we = t.we; be = t.be; addr = BASE + t.off; wdata = t.wdata; has_c = t.has_c; cexp = t.cexp;
          end
        end else if (pro_done && $urandom_range(0, 31) == 0) begin
          req = 1'b0;
        end
      end
      req = 1'b0;
    end

    // Reference model: pending responses as a queue of due cycles, RAM as a word array.
    initial begin
      rsp_t        pend[$];
      rsp_t        p;
      logic [31:0] mem_m [16];
      bit          known_m [16];
      bit          oob_m;
      int unsigned waited;
      int unsigned cyc;
      logic [31:0] last_rd;
      logic [31:0] w;
      int          wi;
      bit          in_r, exp_gnt, exp_rv;
      oob_m = 1'b0; waited = 0; cyc = 0; last_rd = 32'h0;
      for (int k = 0; k < 16; k++) begin
        known_m[k] = 1'b0;
        mem_m[k] = 32'h0;
      end
      forever begin
        @(negedge clk);
        cyc++;
        gnt_seen = req && gnt;
        if (!rst_n) begin
          pend.delete();
          waited = 0; oob_m = 1'b0; last_rd = 32'h0; rd_gnt_now = 1'b0;
          check_val($sformatf("i%0d_rst_gnt", gi), 32'(gnt), 32'h0);
          check_val($sformatf("i%0d_rst_rvalid", gi), 32'(rvalid), 32'h0);
          check_val($sformatf("i%0d_rst_outst", gi), 32'(outstanding), 32'h0);
          check_val($sformatf("i%0d_rst_oob", gi), 32'(oob), 32'h0);
          check_val($sformatf("i%0d_rst_rdata", gi), rdata, 32'h0);
        end else begin
          exp_gnt = req && (pend.size() < MAXO) && (waited >= STALL);
          exp_rv  = (pend.size() != 0) && (pend[0].due == cyc);
          check_val($sformatf("i%0d_gnt", gi), 32'(gnt), 32'(exp_gnt));
          check_val($sformatf("i%0d_rvalid", gi), 32'(rvalid), 32'(exp_rv));
          check_val($sformatf("i%0d_outst", gi), 32'(outstanding), 32'(pend.size()));
          check_val($sformatf("i%0d_oob", gi), 32'(oob), 32'(oob_m));
          if (exp_rv) begin
            p = pend.pop_front();
            if (p.known) check_val($sformatf("i%0d_rdata", gi), rdata, p.data);
            if (p.has_c) check_val($sformatf("i%0d_rdata_dir", gi), rdata, p.cexp);
            last_rd = p.data;
            $display("i%0d cyc=%0d rsp rdata=%h outst=%0d", gi, cyc, rdata, outstanding);
          end else begin
            check_val($sformatf("i%0d_rdata_hold", gi), rdata, last_rd);
          end
          rd_gnt_now = exp_gnt && !we;
          if (exp_gnt) begin
            w    = (addr - BASE) >> 2;
            in_r = (w < DEPTH);
            wi   = (w < 16) ? int'(w[3:0]) : -1;
            p.due   = cyc + LAT;
            p.has_c = has_c;
            p.cexp  = cexp;
            p.known = 1'b1;
            p.data  = 32'h0;
            if (!in_r) begin
              oob_m = 1'b1;
            end else if (wi < 0) begin
              p.known = we;
            end else if (we) begin
              for (int b = 0; b < 4; b++) if (be[b]) mem_m[wi][8*b +: 8] = wdata[8*b +: 8];
              if (be == 4'hF) known_m[wi] = 1'b1;
            end else begin
              p.data  = mem_m[wi];
              p.known = known_m[wi];
            end
            pend.push_back(p);
            waited = 0;
          end else if (req) begin
            waited++;
          end else begin
            waited = 0;
          end
        end
      end
    end
  end

  initial begin
    bit all_done;
    bit found;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    run = 1'b1;
    all_done = 1'b0;
    for (int k = 0; k < 2000 && !all_done; k++) begin
      @(negedge clk);
      all_done = g_inst[0].pro_done && g_inst[1].pro_done && g_inst[2].pro_done && g_inst[3].pro_done;
    end
    check_val("prologue_done", 32'(all_done), 32'h1);
    // Reset one cycle after a read grant on the three-cycle-latency instance.
    found = 1'b0;
    for (int k = 0; k < 500 && !found; k++) begin
      @(negedge clk);
      #1;
      found = g_inst[3].rd_gnt_now;
    end
    check_val("rst_trigger", 32'(found), 32'h1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (RUN_CYCLES) @(posedge clk);
    stop = 1'b1;
    repeat (12) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
